alu_cmd_driver: RTL
===================

Name: alu_cmd_driver

Overview:
- Initiator side of the 4-bit ALU operand/result interface.
- Accepts ALU commands (a, b, sel) over a valid/ready stream and queues them in a small FIFO.
- Drives each command onto the combinational ALU's operand/select inputs, samples result/carry/zero after one settle cycle, and returns them in order over a valid/ready response stream.
- Sits between the control logic and the ALU instance; the ALU itself is external.

Parameters:
DATA_W, 4, operand/result width; must match the ALU
SEL_W, 3, operation select width
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2
CNT_W, 8, width of completed-operation counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO can accept
cmd_a  in  DATA_W  operand A
cmd_b  in  DATA_W  operand B
cmd_sel  in  SEL_W  operation: 000 add, 001 sub, 010 and, 011 or, 100 not A, 101-111 illegal
alu_a  out  DATA_W  registered operand A to ALU
alu_b  out  DATA_W  registered operand B to ALU
alu_sel  out  SEL_W  registered select to ALU
alu_result  in  DATA_W  ALU result
alu_carry  in  1  ALU carry/borrow
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_result  out  DATA_W  captured result
rsp_carry  out  1  captured carry
rsp_zero  out  1  captured zero
rsp_illegal  out  1  command had illegal sel
busy  out  1  FIFO non-empty or FSM not IDLE
op_count  out  CNT_W  number of completed response handshakes, wraps

Behaviour:
- Reset (sync, rst high at an edge):
  - FIFO emptied; FSM goes to IDLE.
  - alu_a/alu_b/alu_sel = 0.
  - rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_illegal = 0.
  - op_count = 0; busy = 0.
  - cmd_ready = 0 while rst is high, 1 on the first cycle after.
  - Reset mid-operation discards queued commands and any in-flight or pending response; no response is ever produced for them.
- Command FIFO:
  - Push on cmd_valid & cmd_ready.
  - cmd_ready = !full, with no bypass; when full, cmd_ready stays 0 even if a pop occurs the same cycle.
  - Order is strictly preserved.
- FSM states: IDLE, DRIVE, RESP.
  - IDLE: if FIFO non-empty, pop head into alu_a/alu_b/alu_sel -> DRIVE; else stay.
  - DRIVE: alu_* held for exactly one full cycle. At the next edge, capture alu_result/alu_carry/alu_zero into rsp_*, set rsp_valid = 1 -> RESP.
  - RESP: rsp_* held stable while rsp_valid & !rsp_ready. On handshake:
    - rsp_valid drops and op_count increments (wraps 2^CNT_W-1 -> 0).
    - If FIFO non-empty, pop next into alu_* the same edge -> DRIVE; else -> IDLE.
- alu_* keep their last value in IDLE and RESP; they are not returned to 0.
- Latency: command pushed at edge E0 into an empty FIFO in IDLE -> alu_* valid after E1 -> rsp_valid high after E2.
- Throughput with rsp_ready held high is one response per 2 cycles.
- Illegal sel (101/110/111):
  - Still driven on alu_sel.
  - Response is forced to rsp_result = 0, rsp_carry = 0, rsp_zero = 1, rsp_illegal = 1, regardless of ALU inputs.
  - rsp_illegal = 0 for legal ops.
- Captured values are passed through from the ALU, never recomputed: sub carry = borrow bit of the 5-bit difference; and/or/not carry = 0.
- Capacity: with rsp_ready = 0, one command sits in RESP and FIFO_DEPTH commands queue, so FIFO_DEPTH+1 commands are accepted before cmd_ready stays low.
- busy = (FIFO non-empty) | (state != IDLE).

Test Plan:
- Bench instantiates the real 4-bit ALU; rsp_ready = 1 unless stated otherwise.
- Add: a=9, b=8, sel=000 -> result=1, carry=1, zero=0; then a=7, b=9 -> result=0, carry=1, zero=1; rsp_valid 2 edges after accept.
- Sub: a=3, b=5, sel=001 -> result=0xE, carry=1; a=5, b=5 -> result=0, carry=0, zero=1.
- Logic: a=0xC, b=0xA: and -> 0x8; or -> 0xE; not -> 0x3. All with carry=0.
- Backpressure: rsp_ready=0, offer 7 commands -> exactly 5 accepted, cmd_ready low afterwards; first response held stable for 10 cycles. Then rsp_ready=1 -> 5 responses in order at one per 2 cycles, op_count=5, busy falls after the last.
- Illegal: a=0xF, b=0xF, sel=110 -> result=0, carry=0, zero=1, illegal=1; next legal add 1+1 -> result=2, illegal=0.
- Reset/wrap:
  - rst asserted while in DRIVE with 3 queued -> next cycle rsp_valid=0, busy=0, alu_*=0, no stale responses afterwards.
  - 256 completed ops -> op_count=0.

Source files
------------

// File: rtl/alu_cmd_driver.sv
`timescale 1ns/1ps
// Initiator for the 4-bit combinational ALU. Queues commands, drives
// operands for one settle cycle, then returns captured flags in order.
module alu_cmd_driver #(
    parameter int DATA_W     = 4,
    parameter int SEL_W      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 * DATA_W + SEL_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [1:0]    state;
    logic [EW-1:0] head;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          illegal_sel;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign cmd_ready = !rst && !full;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr[AW-1:0]];

    assign pop = !empty &&
                 ((state == IDLE) || (state == RESP && rsp_ready));

    assign illegal_sel = (alu_sel > SEL_W'(4));
    assign busy        = !empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_a, cmd_b, cmd_sel};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            state       <= IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_carry   <= 1'b0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr                   <= rd_ptr + (AW+1)'(1);
                {alu_a, alu_b, alu_sel}  <= head;
            end
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                    // Illegal selects never trust whatever the ALU outputs.
                    if (illegal_sel) begin
                        rsp_result  <= '0;
                        rsp_carry   <= 1'b0;
                        rsp_zero    <= 1'b1;
                        rsp_illegal <= 1'b1;
                    end else begin
                        rsp_result  <= alu_result;
                        rsp_carry   <= alu_carry;
                        rsp_zero    <= alu_zero;
                        rsp_illegal <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= empty ? IDLE : DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
